// File: rtl/instr_fetch_if.sv
// Signal bundle between the IF stage and its surroundings: hazard/branch
// controls and the imem load port in, fetch PC and IF/ID register contents out.
interface instr_fetch_if #(
  parameter int ADDR_W = 8
);
  logic              stall;
  logic              flush;
  logic              pc_src;
  logic [31:0]       branch_target;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;

  logic [31:0]       pc;
  logic [31:0]       instruction;
  logic [31:0]       pc_plus4;
  logic              instr_valid;
  logic [31:0]       fetch_count;

  // Environment side: hazard unit, branch resolution and memory loader.
  modport master (
    output stall, flush, pc_src, branch_target,
    output imem_we, imem_waddr, imem_wdata,
    input  pc, instruction, pc_plus4, instr_valid, fetch_count
  );

  // Fetch stage side.
  modport slave (
    input  stall, flush, pc_src, branch_target,
    input  imem_we, imem_waddr, imem_wdata,
    output pc, instruction, pc_plus4, instr_valid, fetch_count
  );
endinterface

// File: rtl/instr_fetch.sv
// IF stage of the 5-stage MIPS pipeline: PC register, loadable word-addressed
// instruction memory and the IF/ID pipeline register with stall/flush/redirect.
module instr_fetch #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic          clk,
  input  logic          reset,
  instr_fetch_if.slave  bus
);

  localparam logic [32:0] MEM_BYTES = 33'(DEPTH) << 2;

  logic [31:0] mem_q [DEPTH];

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;
  logic        instr_valid_q, instr_valid_d;
  logic [31:0] fetch_count_q, fetch_count_d;

  logic [31:0] pc_inc;
  logic [31:0] fetched_word;
  logic        in_range;
  logic        bubble;
  logic        load;
  logic        unused_target_bits;

  assign pc_inc   = pc_q + 32'd4;
  // Anything at or beyond the end of the memory fetches as a NOP.
  assign in_range     = {1'b0, pc_q} < MEM_BYTES;
  assign fetched_word = in_range ? mem_q[pc_q[ADDR_W+1:2]] : 32'h0;

  assign bubble = bus.flush | bus.pc_src;
  assign load   = !bubble && !bus.stall;

  // Redirect targets are forced word-aligned, so the low target bits are dropped.
  assign unused_target_bits = ^bus.branch_target[1:0];

  always_comb begin
    // NOTE: every _d gets its hold value first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    pc_d          = pc_q;
    instr_d       = instr_q;
    pc_plus4_d    = pc_plus4_q;
    instr_valid_d = instr_valid_q;
    fetch_count_d = fetch_count_q;

    if (bus.pc_src) begin
      pc_d = {bus.branch_target[31:2], 2'b00};
    end else if (!bus.stall) begin
      pc_d = pc_inc;
    end

    if (bubble) begin
      instr_d       = 32'h0;
      pc_plus4_d    = 32'h0;
      instr_valid_d = 1'b0;
    end else if (load) begin
      instr_d       = fetched_word;
      pc_plus4_d    = pc_inc;
      instr_valid_d = 1'b1;
      fetch_count_d = fetch_count_q + 32'd1;
    end
  end

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values of the others, matching real hardware.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= 32'h0;
      instr_q       <= 32'h0;
      pc_plus4_q    <= 32'h0;
      instr_valid_q <= 1'b0;
      fetch_count_q <= 32'h0;
    end else begin
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      pc_plus4_q    <= pc_plus4_d;
      instr_valid_q <= instr_valid_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  // NOTE: the memory array has no reset; program contents survive a core
  // reset and a reset port would stop it mapping onto RAM.
  always_ff @(posedge clk) begin
    if (bus.imem_we) begin
      mem_q[bus.imem_waddr] <= bus.imem_wdata;
    end
  end

  assign bus.pc          = pc_q;
  assign bus.instruction = instr_q;
  assign bus.pc_plus4    = pc_plus4_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.fetch_count = fetch_count_q;

  pc_aligned_a : assert property (@(posedge clk) disable iff (reset)
    pc_q[1:0] == 2'b00);

  bubble_empty_a : assert property (@(posedge clk) disable iff (reset)
    !instr_valid_q |-> (instr_q == 32'h0 && pc_plus4_q == 32'h0));

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- IF stage of the 5-stage pipelined MIPS core.
- Holds the PC and a loadable word-addressed instruction memory.
- Drives the IF/ID pipeline register whose `instruction` output feeds the decode stage.
- Supports stall (hazard unit), flush, and branch redirect from the branch-resolution stage.

Parameters:
- DEPTH, 256, number of 32-bit words in the instruction memory.
- ADDR_W, 8, word-index width; must equal clog2(DEPTH).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hold PC and IF/ID register.
- flush  input  1  turn the IF/ID contents into a bubble.
- pc_src  input  1  branch taken; redirect the PC.
- branch_target  input  32  redirect byte address.
- imem_we  input  1  instruction-memory load enable.
- imem_waddr  input  ADDR_W  word index for the load.
- imem_wdata  input  32  load data.
- pc  output  32  current fetch PC (registered).
- instruction  output  32  IF/ID instruction, to decode.
- pc_plus4  output  32  IF/ID PC+4 of that instruction.
- instr_valid  output  1  IF/ID holds a real instruction, not a bubble.
- fetch_count  output  32  number of valid instructions delivered to IF/ID.

Behaviour:
- **Reset** (synchronous, evaluated at the edge, overrides everything): pc=0, instruction=0, pc_plus4=0, instr_valid=0, fetch_count=0. Memory contents are NOT cleared.
- **Memory read:**
  - Combinational: fetched word = imem[pc[ADDR_W+1:2]] when pc < 4*DEPTH; otherwise 32'h0 (NOP).
  - pc[1:0] is ignored for indexing.
- **Memory write:** on the edge when imem_we=1, imem[imem_waddr] <= imem_wdata. A fetch of the same word in that cycle sees the OLD data; the new data is visible from the next cycle. Writes are allowed during stall, flush and redirect.
- **PC update**, per edge when not in reset, in priority order:
  1. pc_src=1: pc <= {branch_target[31:2], 2'b00}. Redirect overrides stall; alignment is forced.
  2. stall=1: pc holds.
  3. Otherwise: pc <= pc + 4, modulo 2^32 (32'hFFFFFFFC wraps to 0).
- **IF/ID update**, per edge when not in reset, in priority order:
  1. flush=1 or pc_src=1: bubble — instruction=0, pc_plus4=0, instr_valid=0. The wrong-path word fetched in the redirect cycle is squashed.
  2. stall=1: all IF/ID fields hold, including instr_valid.
  3. Otherwise: instruction <= fetched word, pc_plus4 <= pc+4, instr_valid <= 1.
- **Combined controls:** flush together with stall produces a bubble. The PC still holds unless pc_src=1.
- **Latency:** the word at PC address A appears on `instruction` one edge after pc==A, assuming no stall, flush or redirect.
- **fetch_count:** increments by 1 on every edge where case 3 of the IF/ID update loads (instr_valid set by a new load). It does not increment on a stall hold. Wraps modulo 2^32.
- **Out-of-range fetch:** delivers instruction=0 with instr_valid=1 (a NOP, counted).
- **Reset mid-operation:** the next edge behaves as reset; fetching restarts from address 0 on the following cycle.
- No combinational path from any input to any output; all outputs are registered.

Test Plan:
- **Sequential fetch:** preload imem[0..3] = 0x8C010000, 0x8C020004, 0x00221820, 0xAC030008; release reset. Required: `instruction` shows the words in order on cycles 1–4, pc_plus4 = 4, 8, 12, 16, instr_valid=1, fetch_count=4 after the 4th load.
- **Stall:** assert stall for 2 cycles while pc=8. Required: pc stays 8; instruction=0x8C020004 and pc_plus4=8 hold; fetch_count unchanged; on release, 0x00221820 loads next.
- **Redirect:** pc_src=1 with branch_target=0x00000013 while pc=12, with stall=1 at the same time. Required: pc becomes 0x10, IF/ID bubble (instr_valid=0, instruction=0), then imem[4] arrives next cycle with pc_plus4=0x14.
- **Flush vs stall:** flush=1 and stall=1 together. Required: bubble loaded, pc holds, fetch_count unchanged.
- **Write/read collision:** imem_we=1, imem_waddr=2, imem_wdata=0x12345678 while pc=8. Required: the old word is fetched this cycle; after branching back to 8, 0x12345678 is fetched.
- **Boundaries:**
  - Redirect to 0x00000400 (DEPTH=256). Required: NOP delivered with instr_valid=1.
  - Redirect to 0xFFFFFFFC. Required: next pc=0.
  - Assert reset mid-run. Required: all outputs 0 at the next edge; memory contents retained.
